// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional watchdog over SEND/ACK/RECOVER enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND,
    S_ACK,
    S_RECOVER
  } state_t;

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be nonzero");
  end

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;

  logic [1:0] clk_pipe;
  logic [1:0] dat_pipe;
  logic       clk_prev;
  logic       clk_sync;
  logic       dat_sync;
  logic       clk_fall;
  logic       wd_fire;

  // Idle bus level is high, so the synchronisers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_pipe <= '1;
      dat_pipe <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_pipe <= {clk_pipe[0], ps2_clock_in};
      dat_pipe <= {dat_pipe[0], ps2_data_in};
      clk_prev <= clk_pipe[1];
    end
  end

  assign clk_sync = clk_pipe[1];
  assign dat_sync = dat_pipe[1];
  assign clk_fall = clk_prev & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == S_SEND) || (state == S_ACK) || (state == S_RECOVER);
  assign wd_fire   = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == S_REQUEST) begin
      wd_cnt <= '0;
    end else if (wd_active && !wd_fire) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      frame        <= '0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            frame        <= {1'b1, ~^tx_data, tx_data};
            bit_cnt      <= '0;
            inh_cnt      <= '0;
            tx_error     <= 1'b0;
            tx_busy      <= 1'b1;
            ps2_clock_oe <= 1'b1;
            ps2_data_oe  <= 1'b0;
            state        <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= S_REQUEST;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_REQUEST: begin
          ps2_clock_oe <= 1'b0;
          state        <= S_SEND;
        end
        S_SEND: begin
          // Frame shifts out LSB first; the 10th edge drives the stop bit (line released).
          if (clk_fall) begin
            ps2_data_oe <= ~frame[0];
            frame       <= {1'b0, frame[9:1]};
            bit_cnt     <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) begin
              state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (clk_fall) begin
            tx_error <= dat_sync;
            state    <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (clk_sync && dat_sync) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (wd_fire) begin
        ps2_clock_oe <= 1'b0;
        ps2_data_oe  <= 1'b0;
        tx_error     <= 1'b1;
        tx_done      <= 1'b1;
        tx_busy      <= 1'b0;
        state        <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, PS/2 device model and a frame/error scoreboard.
// Define PS2_TX_TIMEOUT_EN for both files to exercise the watchdog instead of the silent-hold case.
module tb_ps2_host_tx;

  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       dev_clk;
  logic       dev_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    logic        err;
  } exp_t;

  exp_t sb[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(5000),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  always #5 clock = ~clock;

  // Wired-AND open-drain bus.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic do_start(input logic [7:0] d, input logic ack);
    exp_t e;
    e.data  = d;
    e.frame = make_frame(d);
    e.err   = ~ack;
    sb.push_back(e);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks the frame in, then ACKs (or not) on the 11th pulse.
  // max_falls > 0 stops right after that falling edge with the clock left low.
  task automatic device_respond(input logic ack, input int max_falls,
                                output logic [10:0] got, output logic ok);
    int t = 0;
    ok  = 1'b1;
    got = '0;
    while (!(ps2_clock_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20000) begin
      ok = 1'b0;
      return;
    end
    got[0] = ps2_data_in;
    tick(HALF);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      if (i + 1 == max_falls) begin
        tick(HALF / 2);
        return;
      end
      tick(HALF);
      dev_clk    = 1'b1;
      got[i + 1] = ps2_data_in;
      tick(HALF);
    end
    dev_data = ~ack;
    tick(4);
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic finish_transfer(input logic ack, input string name);
    logic [10:0] got;
    logic        ok;
    int          n = 0;
    exp_t        e;
    device_respond(ack, 0, got, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s_rts: request-to-send not seen, got %0b want 1", name, ok);
    end
    while (tx_done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= 2000 || sb.size() == 0) begin
      fails++;
      $display("FAIL %s_done: tx_done not seen (waited %0d, queue %0d)", name, n, sb.size());
      sb.delete();
      return;
    end
    e = sb.pop_front();
    tests++;
    if (got !== e.frame) begin
      fails++;
      $display("FAIL %s_frame: got %b want %b (data %h)", name, got, e.frame, e.data);
    end
    tests++;
    if (tx_error !== e.err) begin
      fails++;
      $display("FAIL %s_error: got %b want %b", name, tx_error, e.err);
    end
    tests++;
    if ({tx_busy, ps2_clock_oe, ps2_data_oe} !== 3'b000) begin
      fails++;
      $display("FAIL %s_release: busy/clk_oe/dat_oe got %b want 000", name,
               {tx_busy, ps2_clock_oe, ps2_data_oe});
    end
    @(negedge clock);
    tests++;
    if ({tx_done, tx_error} !== {1'b0, e.err}) begin
      fails++;
      $display("FAIL %s_after: done/error got %b want %b", name, {tx_done, tx_error}, {1'b0, e.err});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    tests++;
    if ({ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error});
    end
  endtask

  task automatic test_inhibit_timing;
    int n = 0;
    do_start(8'hED, 1'b1);
    while (ps2_clock_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 6000) begin
      tests++;
      if (tx_busy !== 1'b1 && n == 0) begin
        fails++;
        $display("FAIL inhibit_busy: got %b want 1", tx_busy);
      end
      n++;
      @(negedge clock);
    end
    tests++;
    if (n != 5000) begin
      fails++;
      $display("FAIL inhibit_len: got %0d cycles want 5000", n);
    end
    tests++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b11) begin
      fails++;
      $display("FAIL request_oe: got %b want 11", {ps2_clock_oe, ps2_data_oe});
    end
    @(negedge clock);
    tests++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b01) begin
      fails++;
      $display("FAIL send_oe: got %b want 01", {ps2_clock_oe, ps2_data_oe});
    end
    finish_transfer(1'b1, "ed");
  endtask

  task automatic test_parity;
    do_start(8'hF4, 1'b1);
    finish_transfer(1'b1, "f4");
    do_start(8'h00, 1'b1);
    finish_transfer(1'b1, "zero");
  endtask

  task automatic test_nack;
    do_start(8'hFF, 1'b0);
    finish_transfer(1'b0, "nack");
  endtask

  task automatic test_reset_mid;
    logic [10:0] got;
    logic        ok;
    tx_data  = 8'hED;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    device_respond(1'b1, 5, got, ok);
    tests++;
    if ({ok, tx_busy, ps2_data_oe} !== 3'b111) begin
      fails++;
      $display("FAIL midreset_pre: ok/busy/dat_oe got %b want 111", {ok, tx_busy, ps2_data_oe});
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({ps2_clock_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      fails++;
      $display("FAIL midreset_async: clk_oe/dat_oe/busy got %b want 000",
               {ps2_clock_oe, ps2_data_oe, tx_busy});
    end
    @(negedge clock);
    reset    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick(5);
    do_start(8'h5A, 1'b1);
    finish_transfer(1'b1, "post_reset");
  endtask

  task automatic test_back_to_back;
    logic seen_busy = 1'b0;
    do_start(8'hA5, 1'b1);
    tick(100);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    finish_transfer(1'b1, "b2b_first");
    for (int i = 0; i < 20; i++) begin
      if (tx_busy === 1'b1) seen_busy = 1'b1;
      @(negedge clock);
    end
    tests++;
    if (seen_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_noqueue: busy seen %b want 0", seen_busy);
    end
    do_start(8'h3C, 1'b1);
    finish_transfer(1'b1, "b2b_second");
  endtask

  task automatic test_silent_device;
    int n = 0;
    tx_data  = 8'hED;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    while (!(ps2_clock_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 6000) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= 6000) begin
      fails++;
      $display("FAIL silent_send: SEND not reached after %0d cycles", n);
    end
    n = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (tx_done !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
      if (n == 100) tx_start = 1'b1;
      if (n == 101) tx_start = 1'b0;
    end
    tests++;
    if (n != 2000) begin
      fails++;
      $display("FAIL timeout_len: got %0d cycles want 2000", n);
    end
    tests++;
    if ({tx_error, tx_busy, ps2_clock_oe, ps2_data_oe} !== 4'b1000) begin
      fails++;
      $display("FAIL timeout_state: err/busy/clk_oe/dat_oe got %b want 1000",
               {tx_error, tx_busy, ps2_clock_oe, ps2_data_oe});
    end
    tick(10);
    tests++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: busy got %b want 0", tx_busy);
    end
`else
    while (tx_done !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n != 3000 || {tx_busy, ps2_clock_oe, ps2_data_oe} !== 3'b101) begin
      fails++;
      $display("FAIL silent_hold: cycles %0d (want 3000), busy/clk_oe/dat_oe got %b want 101",
               n, {tx_busy, ps2_clock_oe, ps2_data_oe});
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    tests++;
    if ({tx_busy, ps2_clock_oe, ps2_data_oe} !== 3'b000) begin
      fails++;
      $display("FAIL silent_reset: busy/clk_oe/dat_oe got %b want 000",
               {tx_busy, ps2_clock_oe, ps2_data_oe});
    end
`endif
  endtask

  initial begin
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    test_reset();
    test_inhibit_timing();
    test_parity();
    test_nack();
    test_reset_mid();
    test_back_to_back();
    test_silent_device();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
